// File: rtl/serial_add_unit.sv
// rtl/serial_add_unit.sv - bit-serial ripple adder, one sum bit per clock, LSB first
module serial_add_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic            c;
    logic [CW-1:0]   cnt;
    logic            last_bit;
    logic            bit_sum;
    logic            bit_carry;

    assign last_bit  = (cnt == CW'(WIDTH - 1));
    assign bit_sum   = a_sh[0] ^ b_sh[0] ^ c;
    assign bit_carry = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
    assign busy      = (state == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operands are shifted right so bit 0 of each shift register is always the bit in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh <= '0;
            b_sh <= '0;
            c    <= 1'b0;
            cnt  <= '0;
            s    <= '0;
            cout <= 1'b0;
            done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh <= a;
                        b_sh <= b;
                        c    <= cin;
                        s    <= '0;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    s[cnt] <= bit_sum;
                    c      <= bit_carry;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    cnt    <= cnt + CW'(1);
                    if (last_bit) begin
                        cout <= bit_carry;
                        done <= 1'b1;
                    end
                end
                DONE: begin
                    done <= 1'b0;
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_unit.sv
// tb/tb_serial_add_unit.sv - directed self-checking bench for serial_add_unit
module tb_serial_add_unit;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] s;
    logic       cout;

    int n_checks;
    int n_fail;

    serial_add_unit #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one addition and leaves the DUT back in IDLE afterwards.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                          output logic [7:0] rs, output logic rc,
                          output int lat, output int bcnt, output logic done_after);
        @(negedge clk);
        a = ta; b = tb; cin = tc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; bcnt = 0; rs = 'x; rc = 'x; done_after = 'x;
        while (!done && lat <= 40) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        if (done) begin
            rs = s;
            rc = cout;
        end
        @(posedge clk); #1;
        done_after = done;
    endtask

    logic [7:0] rs;
    logic       rc;
    int         lat;
    int         bcnt;
    logic       dafter;
    int         done_cnt;
    logic [7:0] s_rec;
    logic       c_rec;
    logic       busy9;
    logic       busy10;
    logic [7:0] x;
    logic [7:0] y;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        #12;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_s",    s,    0);
        check("reset_cout", cout, 0);
        @(negedge clk);
        rst = 1'b0;

        // zero operands: 8 busy cycles, single-cycle done
        run_op(8'h00, 8'h00, 1'b0, rs, rc, lat, bcnt, dafter);
        check("zero_latency", lat, 8);
        check("zero_busy_cycles", bcnt, 8);
        check("zero_s", rs, 8'h00);
        check("zero_cout", rc, 0);
        check("zero_done_width", dafter, 0);

        run_op(8'hFF, 8'h01, 1'b0, rs, rc, lat, bcnt, dafter);
        check("ff_01_s", rs, 8'h00);
        check("ff_01_cout", rc, 1);

        run_op(8'h5A, 8'hA5, 1'b1, rs, rc, lat, bcnt, dafter);
        check("5a_a5_c1_s", rs, 8'h00);
        check("5a_a5_c1_cout", rc, 1);

        run_op(8'hC3, 8'h5A, 1'b0, rs, rc, lat, bcnt, dafter);
        repeat (3) @(posedge clk);
        #1;
        check("hold_s", s, 8'h1D);
        check("hold_cout", cout, 1);
        check("hold_done", done, 0);
        check("hold_busy", busy, 0);

        // start held high, operands scrambled during RUN
        @(negedge clk);
        a = 8'h3C; b = 8'h0F; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        done_cnt = 0; s_rec = 'x; c_rec = 'x; busy9 = 'x; busy10 = 'x;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i < 10) begin
                a = ~a;
                b = 8'($urandom);
                cin = ~cin;
            end else begin
                a = 8'h10; b = 8'h20; cin = 1'b0;
            end
            @(posedge clk); #1;
            if (done) begin
                done_cnt++;
                s_rec = s;
                c_rec = cout;
            end
            if (i == 9)  busy9  = busy;
            if (i == 10) busy10 = busy;
        end
        start = 1'b0;
        check("held_done_count", done_cnt, 1);
        check("held_s", s_rec, 8'h4B);
        check("held_cout", c_rec, 0);
        check("held_idle_gap_busy", busy9, 0);
        check("held_restart_busy", busy10, 1);
        lat = 0;
        while (!done && lat <= 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("restart_done", done, 1);
        check("restart_s", s, 8'h30);
        check("restart_cout", cout, 0);
        @(posedge clk); #1;

        // asynchronous reset in the middle of an operation
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        check("async_rst_s",    s,    0);
        check("async_rst_cout", cout, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done || busy) done_cnt++;
        end
        check("aborted_no_done", done_cnt, 0);
        run_op(8'hC3, 8'h5A, 1'b1, rs, rc, lat, bcnt, dafter);
        check("post_rst_latency", lat, 8);
        check("post_rst_s", rs, 8'h1E);
        check("post_rst_cout", rc, 1);

        // subtract-then-add round trip over a spread of (x, y) pairs
        for (int xi = 0; xi <= 37; xi++) begin
            for (int yi = 0; yi <= 29; yi++) begin
                x = (xi == 37) ? 8'hFF : 8'(xi * 7);
                y = (yi == 29) ? 8'hFF : 8'(yi * 9);
                run_op(8'(x - y), y, 1'b0, rs, rc, lat, bcnt, dafter);
                check("inverse_sweep_s", rs, x);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
